// File: rtl/vga_timing_out.sv
// 800x600@60 SVGA raster generator: issues one pixel request per visible pixel and
// drives delay-matched sync and RGB565 outputs from the word returned REQ_LEAD cycles later.
module vga_timing_out #(
    parameter int H_VIS    = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_VIS    = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int REQ_LEAD = 2
) (
    input  logic        CLK_40M,
    input  logic        SYS_RST,
    output logic        VGA_REQ,
    input  logic [15:0] SLCT_OUT_DATA,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [4:0]  VGA_R,
    output logic [5:0]  VGA_G,
    output logic [4:0]  VGA_B,
    output logic        FRAME_START
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
    localparam logic [10:0] H_VISC  = 11'(H_VIS);
    localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0]  V_VISC  = 10'(V_VIS);
    localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;

    logic active_s0, hs_s0, vs_s0, fs_s0;

    // Index 0 is the VGA_REQ stage; index REQ_LEAD feeds the output register.
    logic [REQ_LEAD:0] act_q, act_d;
    logic [REQ_LEAD:0] hs_q, hs_d;
    logic [REQ_LEAD:0] vs_q, vs_d;
    logic [REQ_LEAD:0] fs_q, fs_d;

    logic [15:0] rgb_q, rgb_d;
    logic        hs_out_q, vs_out_q, fs_out_q;

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        active_s0 = (h_cnt_q < H_VISC) && (v_cnt_q < V_VISC);
        hs_s0     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_s0     = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        fs_s0     = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_comb begin
        act_d = {act_q[REQ_LEAD-1:0], active_s0};
        hs_d  = {hs_q[REQ_LEAD-1:0], hs_s0};
        vs_d  = {vs_q[REQ_LEAD-1:0], vs_s0};
        fs_d  = {fs_q[REQ_LEAD-1:0], fs_s0};
        // Returned data is only trusted on cycles that answer a request.
        rgb_d = act_q[REQ_LEAD] ? SLCT_OUT_DATA : '0;
    end

    always_ff @(posedge CLK_40M) begin
        if (SYS_RST) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            act_q    <= '0;
            hs_q     <= '0;
            vs_q     <= '0;
            fs_q     <= '0;
            rgb_q    <= '0;
            hs_out_q <= 1'b0;
            vs_out_q <= 1'b0;
            fs_out_q <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            act_q    <= act_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
            rgb_q    <= rgb_d;
            hs_out_q <= hs_q[REQ_LEAD];
            vs_out_q <= vs_q[REQ_LEAD];
            fs_out_q <= fs_q[REQ_LEAD];
        end
    end

    assign VGA_REQ     = act_q[0];
    assign VGA_HS      = hs_out_q;
    assign VGA_VS      = vs_out_q;
    assign FRAME_START = fs_out_q;
    assign VGA_R       = rgb_q[15:11];
    assign VGA_G       = rgb_q[10:5];
    assign VGA_B       = rgb_q[4:0];

endmodule

// File: tb/tb_vga_timing_out.sv
// Scoreboard bench for vga_timing_out on a shrunken raster, run at REQ_LEAD = 1, 2 and 4
// side by side; expectations come from the cycle index since reset release.
module tb_vga_timing_out;

    localparam int TH_VIS  = 16;
    localparam int TH_FP   = 4;
    localparam int TH_SYNC = 8;
    localparam int TH_BP   = 4;
    localparam int TV_VIS  = 6;
    localparam int TV_FP   = 1;
    localparam int TV_SYNC = 2;
    localparam int TV_BP   = 3;
    localparam int TH_TOT  = TH_VIS + TH_FP + TH_SYNC + TH_BP;
    localparam int TV_TOT  = TV_VIS + TV_FP + TV_SYNC + TV_BP;
    localparam int FR      = TH_TOT * TV_TOT;

    typedef struct packed {
        int          cyc;
        logic        req;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;   // 0: random words, 1: word = requested pixel column, 2: constant all-ones
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic int hpos(int t);
        return (t % FR) % TH_TOT;
    endfunction

    function automatic int vpos(int t);
        return (t % FR) / TH_TOT;
    endfunction

    function automatic logic act(int t);
        return (hpos(t) < TH_VIS) && (vpos(t) < TV_VIS);
    endfunction

    function automatic logic hsync(int t);
        return (hpos(t) >= TH_VIS + TH_FP) && (hpos(t) < TH_VIS + TH_FP + TH_SYNC);
    endfunction

    function automatic logic vsync(int t);
        return (vpos(t) >= TV_VIS + TV_FP) && (vpos(t) < TV_VIS + TV_FP + TV_SYNC);
    endfunction

    // Expected outputs during cycle c, where prev is the word driven during cycle c-1.
    function automatic exp_t model(int c, int lead, logic [15:0] prev);
        exp_t e;
        int   t;
        e     = '0;
        e.cyc = c;
        t     = c - lead - 2;
        if (c >= 1) e.req = act(c - 1);
        if (t >= 0) begin
            e.hs = hsync(t);
            e.vs = vsync(t);
            e.fs = ((t % FR) == 0);
            if (act(t)) e.rgb = prev;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int lead, input int c,
                       input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL L%0d %s cyc %0d got %h exp %h", lead, nm, c, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lead
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        logic        req, hs, vs, fs;
        logic [4:0]  r, b;
        logic [5:0]  gr;
        logic [15:0] din = '0;
        exp_t        q[$];

        vga_timing_out #(
            .H_VIS(TH_VIS), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
            .V_VIS(TV_VIS), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
            .REQ_LEAD(L)
        ) dut (
            .CLK_40M(clk),
            .SYS_RST(rst),
            .VGA_REQ(req),
            .SLCT_OUT_DATA(din),
            .VGA_HS(hs),
            .VGA_VS(vs),
            .VGA_R(r),
            .VGA_G(gr),
            .VGA_B(b),
            .FRAME_START(fs)
        );

        // Stimulus: tracks the cycle index, pushes the expectation, drives the next word.
        initial begin
            int          cyc;
            bit          started;
            logic [15:0] prev;
            logic [15:0] d;
            int          s;
            cyc     = 0;
            started = 1'b0;
            prev    = '0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    cyc     = 0;
                    started = 1'b1;
                end else begin
                    cyc++;
                end
                #1;
                if (started) q.push_back(model(cyc, L, prev));
                d = 16'($urandom);
                if (mode == 1) begin
                    s = cyc - 1 - L;
                    if (!rst && s >= 0 && act(s)) d = 16'(hpos(s));
                end else if (mode == 2) begin
                    d = 16'hFFFF;
                end
                din  = d;
                prev = d;
            end
        end

        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("VGA_REQ",     L, e.cyc, 16'(req), 16'(e.req));
                    chk("VGA_HS",      L, e.cyc, 16'(hs),  16'(e.hs));
                    chk("VGA_VS",      L, e.cyc, 16'(vs),  16'(e.vs));
                    chk("FRAME_START", L, e.cyc, 16'(fs),  16'(e.fs));
                    chk("RGB",         L, e.cyc, {r, gr, b}, e.rgb);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        mode = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FR + 50) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst  = 1'b0;
        mode = 1;
        repeat (2 * FR) @(negedge clk);
        mode = 2;
        repeat (FR + 100) @(negedge clk);
        mode = 0;
        repeat (FR) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
# vga_timing_out

Generates 800x600@60 Hz SVGA raster timing from the 40 MHz system clock and is the consuming end of the pixel-select path. It asserts `VGA_REQ` one pixel at a time, ahead of each visible pixel. It captures the 16-bit RGB565 word returned on `SLCT_OUT_DATA` a fixed number of cycles later. It drives the delay-matched HS/VS and RGB outputs to the VGA connector.

## Interface
Parameters:
- `H_VIS`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (clocks)
- `H_SYNC`, 128, horizontal sync width
- `H_BP`, 88, horizontal back porch
- `V_VIS`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width
- `V_BP`, 23, vertical back porch
- `REQ_LEAD`, 2, cycles from `VGA_REQ` high to matching word valid on `SLCT_OUT_DATA` (legal 1..4)

Ports:
- `CLK_40M`  in  1  40 MHz clock, sole clock
- `SYS_RST`  in  1  reset, synchronous, active-high
- `VGA_REQ`  out  1  pixel request, one cycle per visible pixel
- `SLCT_OUT_DATA`  in  16  returned pixel, RGB565 ({R[15:11],G[10:5],B[4:0]})
- `VGA_HS`  out  1  horizontal sync, active-high
- `VGA_VS`  out  1  vertical sync, active-high
- `VGA_R`  out  5  red
- `VGA_G`  out  6  green
- `VGA_B`  out  5  blue
- `FRAME_START`  out  1  one-cycle pulse aligned with first visible pixel of a frame on RGB outputs

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOT-1 with H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 1056.
  - `v_cnt` runs 0..V_TOT-1 with V_TOT = 628.
  - `v_cnt` increments when `h_cnt` wraps.
  - Both wrap to 0 together at (1055,627).
  - Widths are 11 bits (h) and 10 bits (v), unsigned.
- Stage-0 decode from (h,v):
  - active = h<H_VIS && v<V_VIS
  - hs = H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC, i.e. 840..967
  - vs = V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC, i.e. 601..604
  - fs = (h==0 && v==0)
- `VGA_REQ` is the registered stage-0 `active`: exactly 800 high cycles per visible line, contiguous, 480000 per frame, none during blanking.
- A delay line of REQ_LEAD+1 registers carries `active`, `hs`, `vs` and `fs` past the `VGA_REQ` stage. Its final stage is the output register.
- Output register loads `{VGA_R,VGA_G,VGA_B}` from `SLCT_OUT_DATA` when delayed `active`=1, else 0. Input data during blanking is ignored.
- `VGA_HS`, `VGA_VS` and `FRAME_START` come from the same output register stage as RGB. All outputs are registered; none is combinational from the input.
- No back-pressure: the block never stalls. The upstream supplier must honour REQ_LEAD.

## Timing
- Reset values:
  - counters, all pipeline stages and every output are 0; `VGA_HS`/`VGA_VS` inactive (0).
  - Reset asserted mid-frame takes effect on the next edge: raster restarts at (0,0) and in-flight pipeline contents are discarded, with no partial sync pulse emitted.
- First cycle after reset release:
  - (h,v)=(0,0) at cycle 0.
  - `VGA_REQ`=1 at cycle 1.
  - Pixel word valid at cycle 1+REQ_LEAD and sampled on that edge.
  - `VGA_R/G/B` and `FRAME_START` valid at cycle 2+REQ_LEAD.
- General rule: the counter state at cycle t appears on `VGA_REQ` at t+1 and on the VGA outputs at t+REQ_LEAD+2.
- Line period is 1056 cycles (26.4 us); frame period is 663168 cycles (16.58 ms).
- HS: 128 cycles high per line, starting 40 cycles after the last visible pixel on the outputs.
- VS: high for exactly 4 full lines (4224 cycles), beginning and ending aligned with HS-domain line start, i.e. h=0.
- `FRAME_START`: exactly one pulse per 663168 cycles.

## Test plan
- Reset: hold `SYS_RST` 5 cycles mid-frame -> all outputs 0 during reset; after release `VGA_REQ` rises at cycle 1 and `FRAME_START` pulses at cycle 4 (REQ_LEAD=2).
- Request count: run 1 frame -> `VGA_REQ` high 800 contiguous cycles per line, low 256, exactly 480000 high cycles total, 0 during lines 600..627.
- Sync placement: measure outputs -> HS high 128 cycles, rising 840 cycles after first RGB pixel of the line; VS high 4224 cycles, rising at start of line 601 on outputs.
- Data alignment: model returns `SLCT_OUT_DATA` = pixel index (h) REQ_LEAD cycles after each request -> `VGA_R/G/B` sequence 0,1,2..799 per line with no skipped or repeated values; repeat for REQ_LEAD=1 and 4.
- Blank masking: drive `SLCT_OUT_DATA`=16'hFFFF constantly -> RGB all-ones only during visible region, exactly 0 whenever HS or VS is high.
- Frame wrap: run 2 frames -> `FRAME_START` pulses separated by exactly 663168 cycles; counters wrap (1055,627)->(0,0) with no extra idle cycle.
